// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential Booth multiplier and its adder.
package mul_pkg;

    localparam int WIDTH = 32;
    localparam int ITERS = 32;
    localparam int CNT_W = 6;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    // Booth pair {Q[0], Q_1}
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    typedef struct packed {
        logic [2*WIDTH-1:0] product;
        logic               mul_overflow;
        logic               zero;
    } mul_rsp_t;

    // Overflow means the 64-bit product is not the sign extension of its low word.
    function automatic mul_rsp_t pack_result(input logic [2*WIDTH-1:0] p);
        mul_rsp_t r;
        r.product      = p;
        r.mul_overflow = (p[2*WIDTH-1:WIDTH] != {WIDTH{p[WIDTH-1]}});
        r.zero         = (p == '0);
        return r;
    endfunction

endpackage

// File: rtl/add32.sv
// 32-bit add/subtract unit: Cin=1 inverts B, giving A - B in two's complement.
module ADD32
    import mul_pkg::*;
(
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Add_Result,
    output logic             Add_Carry,
    output logic             Add_Overflow,
    output logic             Add_Sign,
    output logic             Zero
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;

    always_comb begin
        b_eff = Cin ? ~B : B;
        sum   = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, Cin};
    end

    assign Add_Result   = sum[WIDTH-1:0];
    assign Add_Carry    = sum[WIDTH];
    assign Add_Overflow = (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    assign Add_Sign     = sum[WIDTH-1];
    assign Zero         = (sum[WIDTH-1:0] == '0);

endmodule

// File: rtl/booth_mul32.sv
// Sequential signed 32x32->64 radix-2 Booth multiplier; one add/sub/skip per clock
// through a single shared ADD32, 32 iterations per product.
module booth_mul32
    import mul_pkg::*;
#(
    parameter int WIDTH = 32    // ADD32 is fixed-width; only 32 is meaningful
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               mul_overflow,
    output logic               zero
);

    state_t             state;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   q_reg;
    logic [WIDTH-1:0]   m_reg;
    logic               q_1;
    logic [CNT_W-1:0]   cnt;

    logic [1:0]         booth_sel;
    logic               op_add;
    logic               op_sub;
    logic               op_taken;
    logic [WIDTH-1:0]   add_res;
    logic               add_ovf;
    logic [WIDTH-1:0]   a_sel;
    logic               msb_in;
    logic [WIDTH-1:0]   a_next;
    logic [WIDTH-1:0]   q_next;
    logic               last_iter;
    mul_rsp_t           rsp_next;

    assign booth_sel = {q_reg[0], q_1};
    assign op_add    = (booth_sel == BOOTH_ADD);
    assign op_sub    = (booth_sel == BOOTH_SUB);
    assign op_taken  = op_add | op_sub;

    ADD32 u_add (
        .A            (a_reg),
        .B            (m_reg),
        .Cin          (op_sub),
        .Add_Result   (add_res),
        .Add_Carry    (),
        .Add_Overflow (add_ovf),
        .Add_Sign     (),
        .Zero         ()
    );

    // Shifting in the true sign (result MSB xor overflow) keeps A correct when
    // M = -2^31 pushes the partial sum outside 32-bit range.
    always_comb begin
        a_sel    = op_taken ? add_res : a_reg;
        msb_in   = op_taken ? (add_res[WIDTH-1] ^ add_ovf) : a_reg[WIDTH-1];
        a_next   = {msb_in, a_sel[WIDTH-1:1]};
        q_next   = {a_sel[0], q_reg[WIDTH-1:1]};
        rsp_next = pack_result({a_next, q_next});
    end

    assign last_iter = (cnt == CNT_W'(ITERS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            a_reg        <= '0;
            q_reg        <= '0;
            m_reg        <= '0;
            q_1          <= 1'b0;
            cnt          <= '0;
            product      <= '0;
            mul_overflow <= 1'b0;
            zero         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m_reg <= mcand;
                        q_reg <= mplier;
                        a_reg <= '0;
                        q_1   <= 1'b0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_reg <= a_next;
                    q_reg <= q_next;
                    q_1   <= q_reg[0];
                    cnt   <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        product      <= rsp_next.product;
                        mul_overflow <= rsp_next.mul_overflow;
                        zero         <= rsp_next.zero;
                        state        <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_booth_mul32.sv
// Self-checking bench for booth_mul32: vector table plus scoreboard, with
// hand-written sequences for start-while-busy, back-to-back and mid-run reset.
module tb_booth_mul32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] mcand = '0;
    logic [31:0] mplier = '0;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic        mul_overflow;
    logic        zero;

    booth_mul32 #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .mcand        (mcand),
        .mplier       (mplier),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .mul_overflow (mul_overflow),
        .zero         (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] mc;
        logic [31:0] mp;
        logic [63:0] prod;
        logic        ovf;
        logic        zro;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [31:0] mc, input logic [31:0] mp);
        vec_t   v;
        longint p;
        p      = longint'($signed(mc)) * longint'($signed(mp));
        v.mc   = mc;
        v.mp   = mp;
        v.prod = p;
        v.ovf  = (v.prod[63:32] != {32{v.prod[31]}});
        v.zro  = (v.prod == 64'd0);
        return v;
    endfunction

    function automatic vec_t mk(input logic [31:0] mc, input logic [31:0] mp,
                                input logic [63:0] p, input logic o, input logic z);
        vec_t v;
        v.mc = mc; v.mp = mp; v.prod = p; v.ovf = o; v.zro = z;
        return v;
    endfunction

    // Drive a request in IDLE; returns #1 after the accepting edge E0.
    task automatic issue(input vec_t v, input bit hold);
        @(negedge clk);
        mcand  = v.mc;
        mplier = v.mp;
        start  = 1'b1;
        @(posedge clk);
        sb.push_back(v);
        #1;
        if (!hold) start = 1'b0;
    endtask

    // Starting in the cycle after an accept, count edges until done is seen.
    task automatic wait_done(output int edges, output int busy_cnt, output bit ok);
        bit overlap;
        edges    = 0;
        busy_cnt = 0;
        ok       = 1'b0;
        overlap  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy && done) overlap = 1'b1;
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            @(posedge clk);
            edges++;
        end
        chk("busy_done_overlap", 64'(overlap), 64'd0);
        if (!ok) chk("done_timeout", 64'd1, 64'd0);
    endtask

    task automatic check_result(input string tag);
        vec_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_product"}, product, e.prod);
        chk({tag, "_ovf"}, 64'(mul_overflow), 64'(e.ovf));
        chk({tag, "_zero"}, 64'(zero), 64'(e.zro));
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_product"}, product, 64'd0);
        chk({tag, "_ovf"}, 64'(mul_overflow), 64'd0);
        chk({tag, "_zero"}, 64'(zero), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   edges;
        int   bcnt;
        bit   ok;
        vec_t v;

        vecs.push_back(mk(32'd7,        32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 1'b0));
        vecs.push_back(mk(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1, 1'b0));
        vecs.push_back(mk(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b1, 1'b0));
        vecs.push_back(mk(32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b1, 1'b0));
        vecs.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0));
        vecs.push_back(mk(32'h8000_0000, 32'd1,        64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0));
        vecs.push_back(mk(32'h1234_5678, 32'd0,        64'd0,                  1'b0, 1'b1));
        for (int i = 0; i < 4; i++) vecs.push_back(model($urandom, $urandom));

        // Reset state
        #12;
        check_idle_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            issue(vecs[i], 1'b0);
            wait_done(edges, bcnt, ok);
            if (ok) begin
                check_result($sformatf("vec%0d", i));
                // done is sampled after E32, so a clocked consumer sees it on E33.
                chk($sformatf("vec%0d_latency", i), 64'(edges + 1), 64'd33);
                chk($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'd32);
            end
        end

        // start held high through RUN with changing operands, then back-to-back accept.
        issue(mk(32'd0, 32'h1234_5678, 64'd0, 1'b0, 1'b1), 1'b1);
        mcand  = 32'd9;
        mplier = 32'd9;
        wait_done(edges, bcnt, ok);
        if (ok) begin
            check_result("held_start");
            v      = model(32'd5, 32'hFFFF_FFF7);
            mcand  = v.mc;
            mplier = v.mp;
            @(posedge clk);
            #1;
            chk("done_state_ignores_start", 64'(busy), 64'd0);
            chk("done_one_cycle", 64'(done), 64'd0);
            @(posedge clk);
            sb.push_back(v);
            #1;
            start = 1'b0;
            chk("b2b_accepted_busy", 64'(busy), 64'd1);
            chk("product_held", product, 64'd0);
            chk("zero_held", 64'(zero), 64'd1);
            wait_done(edges, bcnt, ok);
            if (ok) begin
                check_result("b2b");
                chk("b2b_throughput", 64'(edges + 2), 64'd34);
            end
        end
        start = 1'b0;

        // Reset on the 10th iteration aborts immediately.
        issue(mk(32'h7FFF_FFFF, 32'd3, 64'h0000_0001_7FFF_FFFD, 1'b1, 1'b0), 1'b0);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_zero("midrun_reset");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", 64'(busy), 64'd0);
        issue(mk(32'd5, 32'd6, 64'd30, 1'b0, 1'b0), 1'b0);
        wait_done(edges, bcnt, ok);
        if (ok) begin
            check_result("after_reset");
            chk("after_reset_latency", 64'(edges + 1), 64'd33);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
